// File: rtl/hex_scan_ctrl.sv
// Purpose: time-multiplexes one hex decoder across DIGITS digits with blanking gaps and leading-zero suppression.
// Latency: registered outputs one cycle behind the scan state; a loaded value appears at the next frame start.
// Backpressure: load_ready drops while a value waits in the pending slot; it reopens after that value is applied.
module hex_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int BLANK  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  lz_blank,
    output logic [3:0]            c,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic                  pending_full_q, pending_full_d;
    logic [3:0]            c_q, c_d;
    logic [DIGITS-1:0]     digit_en_q, digit_en_d;
    logic                  frame_done_q, frame_done_d;

    logic [3:0]            cur_nib;
    logic [DIGITS-1:0]     idx_onehot;
    logic [DIGITS-1:0]     suppress;
    logic                  zero_run;
    logic                  accept;
    logic                  frame_start;

    // Walk from the most significant digit down; a digit is suppressed while every nibble from the top to it is zero.
    always_comb begin
        cur_nib    = 4'h0;
        idx_onehot = '0;
        suppress   = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (shadow_q[4*i +: 4] == 4'h0);
            suppress[i] = lz_blank && (i != 0) && zero_run;
            if (idx_q == IW'(i)) begin
                cur_nib       = shadow_q[4*i +: 4];
                idx_onehot[i] = 1'b1;
            end
        end
    end

    assign accept      = load_valid && !pending_full_q;
    assign frame_start = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST) && (idx_q == '0);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        shadow_d       = shadow_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_done_d   = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == DIV_LAST) begin
                    state_d      = ST_BLANK;
                    cnt_d        = '0;
                    idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    frame_done_d = (idx_q == IDX_LAST);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Swap only at frame start so a frame never mixes old and new digits.
        if (frame_start && pending_full_q) begin
            shadow_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_d      = value_in;
            pending_full_d = 1'b1;
        end

        if (state_q == ST_SHOW) begin
            c_d        = cur_nib;
            digit_en_d = idx_onehot & ~suppress;
        end else begin
            c_d        = 4'h0;
            digit_en_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_BLANK;
            idx_q          <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            c_q            <= 4'h0;
            digit_en_q     <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            c_q            <= c_d;
            digit_en_q     <= digit_en_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign load_ready = !pending_full_q;
    assign c          = c_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule
